vector_add_2_axis_driver: RTL and testbench
===========================================

VECTOR_ADD_2_AXIS_DRIVER -- requirements
Module: vector_add_2_axis_driver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter IN_DATA_LENGHT, default 40, SHALL set the width of the packed operand beat.
REQ-003 Parameter OUT_DATA_LENGHT, default 22, SHALL set the width of the packed result beat.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, SHALL set the number of operand FIFO entries.
REQ-005 Parameter MAX_OUTSTANDING, default 2, SHALL set the maximum number of beats sent whose result has not yet returned.
REQ-006 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  permits launch of new operand beats
- inReady  in  1  one-cycle strobe qualifying A0/A1/B0/B1
- A0, A1, B0, B1  in  10 each  operand elements
- m_axi_data  out  IN_DATA_LENGHT  operand beat
- m_axi_valid  out  1
- m_axi_ready  in  1
- s_axi_data  in  OUT_DATA_LENGHT  result beat
- s_axi_valid  in  1
- s_axi_ready  out  1
- outReady  out  1  one-cycle result strobe
- S0, S1  out  11 each  result elements
- fifo_full  out  1
- busy  out  1  FIFO non-empty, or m_axi_valid high, or outstanding count non-zero
- overflow_err  out  1  sticky
- unexpected_err  out  1  sticky

Function
REQ-007 Packing SHALL be m_axi_data = {A0, A1, B0, B1}, with A0 in bits [39:30] and B1 in bits [9:0].
REQ-008 Unpacking SHALL be S0 = s_axi_data[21:11] and S1 = s_axi_data[10:0], with no sign or width change.
REQ-009 An inReady strobe SHALL push one entry when the FIFO is not full, or when the FIFO is full and a pop occurs in the same cycle.
REQ-010 An inReady strobe with the FIFO full and no same-cycle pop SHALL drop the data and set overflow_err; FIFO contents SHALL be unchanged.
REQ-011 Launch of a new beat SHALL occur only when all of the following hold: enable=1, the FIFO is non-empty, m_axi_valid=0 (or a handshake is completing this cycle), and outstanding < MAX_OUTSTANDING.
REQ-012 Launch SHALL pop the FIFO head into the registered m_axi_data and set m_axi_valid on the next edge.
- Minimum latency from an inReady strobe into an empty FIFO to m_axi_valid=1 is 2 cycles.
REQ-013 Once m_axi_valid=1, m_axi_valid and m_axi_data SHALL stay stable until m_axi_ready=1, regardless of enable.
REQ-014 Back-to-back beats SHALL be supported: a handshake and a new launch in the same cycle keep m_axi_valid=1.
REQ-015 The outstanding counter SHALL increment on each m_axi handshake and decrement on each s_axi handshake.
- A simultaneous increment and decrement leaves it unchanged.
REQ-016 s_axi_ready SHALL be 1 in every cycle after reset release.
REQ-017 An s_axi handshake SHALL register S0/S1 and pulse outReady high for exactly one cycle on the next edge.
- S0/S1 hold their value until the next result.
REQ-018 An s_axi handshake with outstanding=0 and no same-cycle m_axi handshake SHALL set unexpected_err and still deliver the result.
- The counter SHALL NOT wrap.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy is tracked with a count of width log2(FIFO_DEPTH)+1.
REQ-020 fifo_full SHALL equal (count == FIFO_DEPTH), registered.

Reset
REQ-021 Reset SHALL clear the following to 0: m_axi_valid, m_axi_data, outReady, S0, S1, s_axi_ready, both sticky errors, FIFO count and pointers, and the outstanding counter.
REQ-022 Reset asserted mid-operation SHALL discard all queued and in-flight beats.
- m_axi_valid SHALL be 0 in the cycle after the reset edge.
REQ-023 FIFO storage SHALL NOT require reset.

Structure
REQ-024 The shared package SHALL hold the element widths (10 in, 11 out), the field bit offsets, and the default parameter values.
REQ-025 The operand FIFO SHALL be one sub-module, sync_fifo, parameterised by width and depth, with push/pop/full/empty/count ports.
REQ-026 The AXI-Stream launch logic, outstanding counter and result capture SHALL reside in the top module.

Verification
REQ-027 Single operation: inReady with A0=1, A1=2, B0=3, B1=4 and m_axi_ready=1 -> m_axi_data=0x0040200C04 two cycles later; return s_axi_data={11'd4, 11'd6} -> outReady pulse, S0=4, S1=6.
REQ-028 Backpressure: m_axi_ready=0 for 5 cycles with 3 pushes -> m_axi_data stable; then ready=1 -> 3 beats in push order, with at most MAX_OUTSTANDING=2 sent before the first result returns.
REQ-029 Overflow: 6 pushes with enable=0 -> fifo_full=1 after the 4th; 5th and 6th dropped; overflow_err=1; 4 beats emitted after enable=1.
REQ-030 Unexpected result: s_axi_valid=1 with nothing outstanding -> unexpected_err=1, outReady pulse, outstanding stays 0.
REQ-031 Reset mid-flight: reset with 2 entries queued and m_axi_valid=1 -> next cycle all outputs 0; busy=0 after reset release.
REQ-032 Simultaneous events: push while full with a same-cycle pop -> accepted, count stays 4, no overflow_err.

Source files
------------

// File: rtl/vector_add_2_axis_driver_pkg.sv
// Shared widths, field offsets and default parameters for the vector-add AXI-Stream driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vector_add_2_axis_driver_pkg;

    // Element widths: operands are 10 bits, sums carry one extra bit
    localparam int IN_ELEM_W  = 10;
    localparam int OUT_ELEM_W = 11;

    // Operand beat layout {A0, A1, B0, B1}, A0 in the most significant field
    localparam int A0_LSB = 30;
    localparam int A1_LSB = 20;
    localparam int B0_LSB = 10;
    localparam int B1_LSB = 0;

    // Result beat layout {S0, S1}
    localparam int S0_LSB = 11;
    localparam int S1_LSB = 0;

    // Default parameter values
    localparam int DEF_IN_DATA_LENGHT  = 40;
    localparam int DEF_OUT_DATA_LENGHT = 22;
    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/vector_add_2_axis_driver_sync_fifo.sv
// Generic synchronous FIFO: combinational head read, registered count/full/empty.
// Latency: a pushed entry is visible at the head (empty=0) one cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [AW:0]      count_next;

    // A pop frees the slot the write lands in, so a full FIFO still accepts
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vector_add_2_axis_driver.sv
// Queues operand vectors, streams them out on an AXI-Stream master and captures sum results.
// Latency: inReady to m_axi_valid is 2 cycles minimum; s_axi handshake to outReady is 1 cycle.
// Backpressure: m_axi beat held stable until m_axi_ready; launches stall at MAX_OUTSTANDING; overflowing pushes dropped.
// Ports: clk/reset, enable, inReady+A0/A1/B0/B1 in, m_axi_* master, s_axi_* slave,
//        outReady+S0/S1 out, fifo_full, busy, sticky overflow_err/unexpected_err.
module vector_add_2_axis_driver
    import vector_add_2_axis_driver_pkg::*;
#(
    parameter int IN_DATA_LENGHT  = DEF_IN_DATA_LENGHT,
    parameter int OUT_DATA_LENGHT = DEF_OUT_DATA_LENGHT,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       inReady,
    input  logic [IN_ELEM_W-1:0]       A0,
    input  logic [IN_ELEM_W-1:0]       A1,
    input  logic [IN_ELEM_W-1:0]       B0,
    input  logic [IN_ELEM_W-1:0]       B1,
    output logic [IN_DATA_LENGHT-1:0]  m_axi_data,
    output logic                       m_axi_valid,
    input  logic                       m_axi_ready,
    input  logic [OUT_DATA_LENGHT-1:0] s_axi_data,
    input  logic                       s_axi_valid,
    output logic                       s_axi_ready,
    output logic                       outReady,
    output logic [OUT_ELEM_W-1:0]      S0,
    output logic [OUT_ELEM_W-1:0]      S1,
    output logic                       fifo_full,
    output logic                       busy,
    output logic                       overflow_err,
    output logic                       unexpected_err
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [IN_DATA_LENGHT-1:0] fifo_wdata;
    logic [IN_DATA_LENGHT-1:0] fifo_rdata;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [OW-1:0]             outstanding;
    logic [OW:0]               committed;
    logic [OW:0]               limit;
    logic                      m_hs;
    logic                      s_hs;
    logic                      dec;
    logic                      launch;

    assign fifo_wdata = IN_DATA_LENGHT'({A0, A1, B0, B1});

    sync_fifo #(
        .WIDTH (IN_DATA_LENGHT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inReady),
        .wdata (fifo_wdata),
        .pop   (launch),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_hs = m_axi_valid && m_axi_ready;
    assign s_hs = s_axi_valid && s_axi_ready;
    // A result only frees a slot if the counter really decrements this cycle
    assign dec  = s_hs && ((outstanding != '0) || m_hs);

    // The beat sitting in the output register counts against the limit as well,
    // otherwise a back-to-back launch could put MAX_OUTSTANDING+1 beats on the wire.
    always_comb begin
        committed = {1'b0, outstanding} + (OW+1)'(m_axi_valid);
        limit     = (OW+1)'(MAX_OUTSTANDING) + (OW+1)'(dec);
        launch    = enable && !fifo_empty && (!m_axi_valid || m_axi_ready) && (committed < limit);
    end

    assign busy = !fifo_empty || m_axi_valid || (outstanding != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi_valid    <= 1'b0;
            m_axi_data     <= '0;
            s_axi_ready    <= 1'b0;
            outReady       <= 1'b0;
            S0             <= '0;
            S1             <= '0;
            outstanding    <= '0;
            overflow_err   <= 1'b0;
            unexpected_err <= 1'b0;
        end else begin
            s_axi_ready <= 1'b1;

            if (launch) begin
                m_axi_valid <= 1'b1;
                m_axi_data  <= fifo_rdata;
            end else if (m_hs) begin
                m_axi_valid <= 1'b0;
            end

            case ({m_hs, dec})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            outReady <= s_hs;
            if (s_hs) begin
                S0 <= s_axi_data[S0_LSB +: OUT_ELEM_W];
                S1 <= s_axi_data[S1_LSB +: OUT_ELEM_W];
            end

            if (inReady && fifo_full && !launch) overflow_err <= 1'b1;
            // A stray result is still delivered; the counter is held at zero
            if (s_hs && (outstanding == '0) && !m_hs) unexpected_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_add_2_axis_driver.sv
module tb_vector_add_2_axis_driver;
    import vector_add_2_axis_driver_pkg::*;

    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        inReady = 1'b0;
    logic [9:0]  A0 = '0, A1 = '0, B0 = '0, B1 = '0;
    logic [39:0] m_axi_data;
    logic        m_axi_valid;
    logic        m_axi_ready = 1'b0;
    logic [21:0] s_axi_data = '0;
    logic        s_axi_valid = 1'b0;
    logic        s_axi_ready;
    logic        outReady;
    logic [10:0] S0, S1;
    logic        fifo_full, busy, overflow_err, unexpected_err;

    int checks = 0;
    int failures = 0;
    int model_out = 0;
    bit resp_en = 1'b0;

    logic [39:0] beat_q[$];
    logic [21:0] exp_res_q[$];
    logic [21:0] resp_q[$];

    always #5 clk = ~clk;

    vector_add_2_axis_driver dut (
        .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .m_axi_data(m_axi_data), .m_axi_valid(m_axi_valid), .m_axi_ready(m_axi_ready),
        .s_axi_data(s_axi_data), .s_axi_valid(s_axi_valid), .s_axi_ready(s_axi_ready),
        .outReady(outReady), .S0(S0), .S1(S1), .fifo_full(fifo_full), .busy(busy),
        .overflow_err(overflow_err), .unexpected_err(unexpected_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] pack(input logic [9:0] a0, input logic [9:0] a1,
                                         input logic [9:0] b0, input logic [9:0] b1);
        return {a0, a1, b0, b1};
    endfunction

    function automatic logic [21:0] vsum(input logic [9:0] a0, input logic [9:0] a1,
                                         input logic [9:0] b0, input logic [9:0] b1);
        logic [10:0] s0, s1;
        s0 = {1'b0, a0} + {1'b0, b0};
        s1 = {1'b0, a1} + {1'b0, b1};
        return {s0, s1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] a0, input logic [9:0] a1,
                        input logic [9:0] b0, input logic [9:0] b1, input bit acc);
        A0 = a0; A1 = a1; B0 = b0; B1 = b1;
        inReady = 1'b1;
        if (acc) begin
            beat_q.push_back(pack(a0, a1, b0, b1));
            exp_res_q.push_back(vsum(a0, a1, b0, b1));
        end
        tick();
        inReady = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (beat_q.size() == 0 && resp_q.size() == 0 && exp_res_q.size() == 0 &&
                !busy && !s_axi_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    // Monitor: handshakes and result strobes, sampled mid-cycle
    initial begin
        logic [39:0] d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (s_axi_valid && s_axi_ready) begin
                    if (resp_q.size() > 0) void'(resp_q.pop_front());
                    if (model_out > 0) model_out--;
                end
                if (m_axi_valid && m_axi_ready) begin
                    chk("max_outstanding", 64'(model_out < MAX_OUT), 64'd1);
                    if (beat_q.size() > 0) chk("beat", 64'(m_axi_data), 64'(beat_q.pop_front()));
                    else chk("unexpected_beat", 64'd1, 64'd0);
                    model_out++;
                    d = m_axi_data;
                    resp_q.push_back(vsum(d[39:30], d[29:20], d[19:10], d[9:0]));
                end
                if (outReady) begin
                    if (exp_res_q.size() > 0) begin
                        d = {18'd0, exp_res_q.pop_front()};
                        chk("S0", 64'(S0), 64'(d[21:11]));
                        chk("S1", 64'(S1), 64'(d[10:0]));
                    end else begin
                        chk("spurious_outReady", 64'd1, 64'd0);
                    end
                end
            end
        end
    end

    // Remote accelerator: returns the head of resp_q while enabled
    initial begin
        forever begin
            tick();
            if (resp_en && !reset && resp_q.size() > 0) begin
                s_axi_valid = 1'b1;
                s_axi_data  = resp_q[0];
            end else begin
                s_axi_valid = 1'b0;
                s_axi_data  = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_m_valid", 64'(m_axi_valid), 64'd0);
        chk("rst_m_data", 64'(m_axi_data), 64'd0);
        chk("rst_outReady", 64'(outReady), 64'd0);
        chk("rst_S0", 64'(S0), 64'd0);
        chk("rst_S1", 64'(S1), 64'd0);
        chk("rst_s_ready", 64'(s_axi_ready), 64'd0);
        chk("rst_errs", 64'({overflow_err, unexpected_err}), 64'd0);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("s_ready_after_rst", 64'(s_axi_ready), 64'd1);

        // Single operation with latency check
        enable = 1'b1; m_axi_ready = 1'b1; resp_en = 1'b1;
        push(10'd1, 10'd2, 10'd3, 10'd4, 1'b1);
        chk("lat1_valid", 64'(m_axi_valid), 64'd0);
        tick();
        chk("lat2_valid", 64'(m_axi_valid), 64'd1);
        chk("single_data", 64'(m_axi_data), 64'h00_4020_0C04);
        drain("single_drain");
        chk("single_S0_hold", 64'(S0), 64'd4);
        chk("single_S1_hold", 64'(S1), 64'd6);
        chk("single_no_unexp", 64'(unexpected_err), 64'd0);

        // Backpressure, then outstanding limit with results withheld
        m_axi_ready = 1'b0; resp_en = 1'b0;
        push(10'd5, 10'd6, 10'd7, 10'd8, 1'b1);
        push(10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
        push(10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(m_axi_valid), 64'd1);
            chk("bp_stable", 64'(m_axi_data), 64'(pack(10'd5, 10'd6, 10'd7, 10'd8)));
            tick();
        end
        m_axi_ready = 1'b1;
        repeat (6) tick();
        chk("bp_outstanding", 64'(model_out), 64'd2);
        chk("bp_third_held", 64'(beat_q.size()), 64'd1);
        chk("bp_valid_low", 64'(m_axi_valid), 64'd0);
        resp_en = 1'b1;
        drain("bp_drain");

        // Push into a full FIFO while the head pops in the same cycle
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(10'(i + 20), 10'(i + 30), 10'(i + 40), 10'(i + 50), 1'b1);
        chk("simul_full_before", 64'(fifo_full), 64'd1);
        enable = 1'b1;
        push(10'd100, 10'd200, 10'd300, 10'd400, 1'b1);
        chk("simul_full_after", 64'(fifo_full), 64'd1);
        chk("simul_no_ovf", 64'(overflow_err), 64'd0);
        drain("simul_drain");

        // Overflow: six pushes with launches disabled
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push(10'(i + 60), 10'(i + 61), 10'(i + 62), 10'(i + 63), 1'b1);
        chk("ovf_not_full_3", 64'(fifo_full), 64'd0);
        push(10'd70, 10'd71, 10'd72, 10'd73, 1'b1);
        chk("ovf_full_4", 64'(fifo_full), 64'd1);
        chk("ovf_err_clear", 64'(overflow_err), 64'd0);
        push(10'd80, 10'd81, 10'd82, 10'd83, 1'b0);
        push(10'd90, 10'd91, 10'd92, 10'd93, 1'b0);
        chk("ovf_err", 64'(overflow_err), 64'd1);
        chk("ovf_still_full", 64'(fifo_full), 64'd1);
        enable = 1'b1;
        drain("ovf_drain");

        // Unexpected result with nothing outstanding
        chk("unexp_idle", 64'(busy), 64'd0);
        resp_q.push_back({11'd5, 11'd7});
        exp_res_q.push_back({11'd5, 11'd7});
        repeat (4) tick();
        chk("unexp_err", 64'(unexpected_err), 64'd1);
        chk("unexp_busy", 64'(busy), 64'd0);
        chk("unexp_S0", 64'(S0), 64'd5);
        chk("unexp_S1", 64'(S1), 64'd7);
        drain("unexp_drain");

        // Reset with a beat on the wire and two entries queued
        m_axi_ready = 1'b0; resp_en = 1'b0;
        push(10'd11, 10'd12, 10'd13, 10'd14, 1'b1);
        push(10'd15, 10'd16, 10'd17, 10'd18, 1'b1);
        push(10'd19, 10'd20, 10'd21, 10'd22, 1'b1);
        chk("mid_valid", 64'(m_axi_valid), 64'd1);
        reset = 1'b1;
        tick();
        beat_q.delete(); exp_res_q.delete(); resp_q.delete(); model_out = 0;
        chk("mid_rst_valid", 64'(m_axi_valid), 64'd0);
        chk("mid_rst_data", 64'(m_axi_data), 64'd0);
        chk("mid_rst_outs", 64'({outReady, S0, S1}), 64'd0);
        chk("mid_rst_errs", 64'({overflow_err, unexpected_err}), 64'd0);
        chk("mid_rst_full", 64'(fifo_full), 64'd0);
        reset = 1'b0;
        tick();
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_valid_after", 64'(m_axi_valid), 64'd0);
        chk("mid_s_ready", 64'(s_axi_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
